// File: rtl/rsa_pkg.sv
// Shared RSA datapath definitions: Montgomery multiplier state encoding and latency.
package rsa_pkg;

    typedef enum logic [1:0] {
        MMM_IDLE = 2'd0,
        MMM_CALC = 2'd1,
        MMM_CORR = 2'd2,
        MMM_DONE = 2'd3
    } mmm_state_t;

    // Enabled clocks from the accepted start edge to the first cycle of done.
    function automatic int mmm_latency(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/mmm_iter.sv
// Combinational radix-2 Montgomery step: R_next = (R + a_i*B + q*M) >> 1.
module mmm_iter #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] r,
    input  logic             a_bit,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH+1:0] r_next
);

    logic [WIDTH+2:0] t_s;
    logic [WIDTH+2:0] sum_s;

    // One extra bit keeps the sum exact even for out-of-contract operands.
    always_comb begin
        if (a_bit) begin
            t_s = {1'b0, r} + {3'b000, b};
        end else begin
            t_s = {1'b0, r};
        end
        if (t_s[0]) begin
            sum_s = t_s + {3'b000, m};
        end else begin
            sum_s = t_s;
        end
    end

    assign r_next = sum_s[WIDTH+2:1];

endmodule

// File: rtl/mmm_serial.sv
// Bit-serial Montgomery multiplier, P = A*B*2^-WIDTH mod M, one bit of A per enabled clock.
// Optional even-modulus rejection is built when MMM_OPERAND_CHECK_EN is defined.
module mmm_serial
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] p
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ITERS = mmm_latency(WIDTH) - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    mmm_state_t       state_r;
    mmm_state_t       state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH+1:0] acc_r;
    logic [WIDTH+1:0] acc_next_s;
    logic [WIDTH+1:0] diff_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] corr_s;
    logic             load_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] p_r;
`ifdef MMM_OPERAND_CHECK_EN
    logic             bad_m_s;
    logic             err_r;
`endif

    mmm_iter #(.WIDTH(WIDTH)) u_iter (
        .r      (acc_r),
        .a_bit  (a_r[0]),
        .b      (b_r),
        .m      (m_r),
        .r_next (acc_next_s)
    );

    // Final conditional subtraction: R < 2M, so one subtraction suffices.
    always_comb begin
        diff_s = acc_r - {2'b00, m_r};
        if (acc_r >= {2'b00, m_r}) begin
            corr_s = diff_s[WIDTH-1:0];
        end else begin
            corr_s = acc_r[WIDTH-1:0];
        end
    end

    // Next-state and operand-load decode.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
`ifdef MMM_OPERAND_CHECK_EN
        bad_m_s = 1'b0;
`endif
        case (state_r)
            MMM_IDLE: begin
                if (start) begin
`ifdef MMM_OPERAND_CHECK_EN
                    if (!m[0]) begin
                        state_s = MMM_DONE;
                        bad_m_s = 1'b1;
                    end else begin
                        state_s = MMM_CALC;
                        load_s  = 1'b1;
                    end
`else
                    state_s = MMM_CALC;
                    load_s  = 1'b1;
`endif
                end else begin
                    state_s = MMM_IDLE;
                end
            end
            MMM_CALC: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = MMM_CORR;
                end else begin
                    state_s = MMM_CALC;
                end
            end
            MMM_CORR: state_s = MMM_DONE;
            MMM_DONE: state_s = MMM_IDLE;
            default:  state_s = MMM_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= MMM_IDLE;
        end else if (ena) begin
            state_r <= state_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Operand registers, accumulator and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            m_r   <= {WIDTH{1'b0}};
            acc_r <= {(WIDTH+2){1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (ena) begin
            if (load_s) begin
                a_r   <= a;
                b_r   <= b;
                m_r   <= m;
                acc_r <= {(WIDTH+2){1'b0}};
                cnt_r <= {CNT_W{1'b0}};
            end else if (state_r == MMM_CALC) begin
                acc_r <= acc_next_s;
                a_r   <= {1'b0, a_r[WIDTH-1:1]};
                if (cnt_r != CNT_LAST) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
            end else begin
                acc_r <= acc_r;
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    // Registered status and result; p only changes on correction or rejection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            p_r    <= {WIDTH{1'b0}};
        end else if (ena) begin
            busy_r <= (state_s == MMM_CALC) || (state_s == MMM_CORR);
            done_r <= (state_s == MMM_DONE);
            if (state_r == MMM_CORR) begin
                p_r <= corr_s;
`ifdef MMM_OPERAND_CHECK_EN
            end else if (bad_m_s) begin
                p_r <= {WIDTH{1'b0}};
`endif
            end else begin
                p_r <= p_r;
            end
        end else begin
            p_r <= p_r;
        end
    end

`ifdef MMM_OPERAND_CHECK_EN
    // Error flag: set on rejected even modulus, cleared by any accepted computation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (ena) begin
            if (bad_m_s) begin
                err_r <= 1'b1;
            end else if (load_s) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign busy = busy_r;
    assign done = done_r;
    assign p    = p_r;

endmodule

// File: tb/tb_mmm_serial.sv
// Self-checking bench for mmm_serial (WIDTH=8) against a modular-arithmetic reference.
module tb_mmm_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = 8'd0;
    logic [W-1:0] b = 8'd0;
    logic [W-1:0] m = 8'd1;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] p;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_lat;

    mmm_serial #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start),
        .a(a), .b(b), .m(m),
        .busy(busy), .done(done), .err(err), .p(p)
    );

    always #5 clk = ~clk;

    // Reference: the unique p in [0,m) with p*2^W == a*b (mod m), m odd.
    function automatic logic [W-1:0] ref_mont(input int ra, input int rb, input int rm);
        int prod;
        prod = (ra * rb) % rm;
        for (int k = 0; k < rm; k++) begin
            if (((k * 256) % rm) == prod) return 8'(k);
        end
        return 8'd0;
    endfunction

    // Issue one start, scramble inputs afterwards, optionally stall ena or pulse start.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] im,
                          input int stall_at, input int stall_len, input int pulse_at,
                          output int lat, output int busy_cnt, output logic [W-1:0] rp, output logic rerr);
        for (int k = 0; k < 50 && (busy || done); k++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        a = ia; b = ib; m = im; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            ena   = !(lat >= stall_at && lat < stall_at + stall_len);
            start = (lat == pulse_at);
            a = 8'($urandom); b = 8'($urandom); m = 8'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        ena = 1'b1; start = 1'b0;
        rp = p; rerr = err;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        n_checks++; if (p !== 8'd0) begin n_fail++; $display("FAIL reset_p got %0d want 0", p); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        int ta[4] = '{5, 12, 254, 0};
        int tb[4] = '{7, 12, 254, 9};
        int tm[4] = '{13, 13, 255, 13};
        int lat, bc; logic [W-1:0] rp; logic re;
        for (int i = 0; i < 4; i++) begin
            run_op(8'(ta[i]), 8'(tb[i]), 8'(tm[i]), 1000, 0, 1000, lat, bc, rp, re);
            n_checks++; if (rp !== ref_mont(ta[i], tb[i], tm[i])) begin n_fail++; $display("FAIL basic_p[%0d] got %0d want %0d", i, rp, ref_mont(ta[i], tb[i], tm[i])); end
            n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL basic_latency[%0d] got %0d want %0d", i, lat, exp_lat); end
            n_checks++; if (bc != exp_lat) begin n_fail++; $display("FAIL basic_busy_cycles[%0d] got %0d want %0d", i, bc, exp_lat); end
            n_checks++; if (re !== 1'b0) begin n_fail++; $display("FAIL basic_err[%0d] got %b want 0", i, re); end
        end
    endtask

    task automatic test_ignored_start();
        int lat, bc, extra; logic [W-1:0] rp; logic re;
        run_op(8'd0, 8'd9, 8'd13, 1000, 0, 3, lat, bc, rp, re);
        n_checks++; if (rp !== 8'd0) begin n_fail++; $display("FAIL ignored_p got %0d want 0", rp); end
        n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL ignored_latency got %0d want %0d", lat, exp_lat); end
        extra = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL ignored_extra_activity got %0d cycles want 0", extra); end
    endtask

    task automatic test_ena_stall();
        int lat, bc; logic [W-1:0] rp; logic re;
        run_op(8'd5, 8'd7, 8'd13, 3, 3, 1000, lat, bc, rp, re);
        n_checks++; if (rp !== 8'd1) begin n_fail++; $display("FAIL stall_p got %0d want 1", rp); end
        n_checks++; if (lat != exp_lat + 3) begin n_fail++; $display("FAIL stall_latency got %0d want %0d", lat, exp_lat + 3); end
        ena = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stall_done_held got %b want 1", done); end
        ena = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL stall_done_release got %b want 0", done); end
    endtask

    task automatic test_reset_mid();
        int lat, bc; logic [W-1:0] rp; logic re;
        run_op(8'd5, 8'd7, 8'd13, 1000, 0, 1000, lat, bc, rp, re);
        for (int k = 0; k < 50 && (busy || done); k++) begin @(posedge clk); #1; end
        @(negedge clk);
        a = 8'd12; b = 8'd12; m = 8'd13; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #2; rst = 1'b1; #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", done); end
        n_checks++; if (p !== 8'd0) begin n_fail++; $display("FAIL midrst_p got %0d want 0", p); end
        @(negedge clk); rst = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_discard got busy=%b done=%b want 0 0", busy, done); end
        run_op(8'd12, 8'd12, 8'd13, 1000, 0, 1000, lat, bc, rp, re);
        n_checks++; if (rp !== 8'd3) begin n_fail++; $display("FAIL midrst_after_p got %0d want 3", rp); end
        n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL midrst_after_latency got %0d want %0d", lat, exp_lat); end
    endtask

    task automatic test_even_modulus();
        int lat, bc; logic [W-1:0] rp; logic re;
        run_op(8'd5, 8'd7, 8'd12, 1000, 0, 1000, lat, bc, rp, re);
`ifdef MMM_OPERAND_CHECK_EN
        n_checks++; if (lat != 0) begin n_fail++; $display("FAIL even_latency got %0d want 0", lat); end
        n_checks++; if (re !== 1'b1) begin n_fail++; $display("FAIL even_err got %b want 1", re); end
        n_checks++; if (rp !== 8'd0) begin n_fail++; $display("FAIL even_p got %0d want 0", rp); end
        n_checks++; if (bc != 0) begin n_fail++; $display("FAIL even_busy_cycles got %0d want 0", bc); end
`else
        n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL even_latency got %0d want %0d", lat, exp_lat); end
        n_checks++; if (re !== 1'b0) begin n_fail++; $display("FAIL even_err got %b want 0", re); end
`endif
    endtask

    task automatic test_back_to_back();
        int lat, bc; logic [W-1:0] rp; logic re;
        run_op(8'd5, 8'd7, 8'd13, 1000, 0, 1000, lat, bc, rp, re);
        @(negedge clk);
        a = 8'd12; b = 8'd12; m = 8'd13; start = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_in_done got busy=%b done=%b want 0 0", busy, done); end
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
        lat = 0;
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", lat, exp_lat); end
        n_checks++; if (p !== 8'd3) begin n_fail++; $display("FAIL b2b_p got %0d want 3", p); end
    endtask

    task automatic test_random();
        int lat, bc, rm, ra, rb; logic [W-1:0] rp; logic re;
        for (int i = 0; i < 20; i++) begin
            rm = int'($urandom_range(3, 255)) | 1;
            ra = int'($urandom_range(0, rm - 1));
            rb = int'($urandom_range(0, rm - 1));
            run_op(8'(ra), 8'(rb), 8'(rm), 1000, 0, 1000, lat, bc, rp, re);
            n_checks++; if (rp !== ref_mont(ra, rb, rm)) begin n_fail++; $display("FAIL rand_p a=%0d b=%0d m=%0d got %0d want %0d", ra, rb, rm, rp, ref_mont(ra, rb, rm)); end
            n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL rand_latency got %0d want %0d", lat, exp_lat); end
        end
    endtask

    initial begin
        exp_lat = rsa_pkg::mmm_latency(W);
        test_reset();
        test_basic();
        test_ignored_start();
        test_ena_stall();
        test_reset_mid();
        test_even_modulus();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
